// File: rtl/axil_cfg_slave_pkg.sv
// Shared definitions for the AXI4-Lite configuration slave: bus widths,
// response codes, FSM state encoding and arbitration grant encoding.
package axil_cfg_slave_pkg;

  localparam int unsigned CGRA_AXI_ADDR_WIDTH = 32;
  localparam int unsigned CGRA_AXI_DATA_WIDTH = 32;

  localparam logic [1:0] AXIL_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_RESP = 3'd5
  } axil_state_e;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } axil_grant_e;

  // Only word-aligned accesses reach the config bus.
  function automatic logic addr_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/axil_cfg_slave_skid.sv
// One-entry holding buffer for an AXI4-Lite request channel (AW or W).
// Ready while empty; the consumer empties it with pop_i.
module axil_skid_reg
  import axil_cfg_slave_pkg::*;
#(
  parameter int unsigned WIDTH = CGRA_AXI_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end else if (valid_i && !full_q) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end
  end

  assign ready_o = ~full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axil_cfg_slave.sv
// AXI4-Lite slave bridging to a simple strobe-based config bus; one config
// operation in flight, round-robin between a ready write and a pending read.
module axil_cfg_slave
  import axil_cfg_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CGRA_AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CGRA_AXI_DATA_WIDTH,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  cfg_wr_en,
  output logic                  cfg_rd_en,
  output logic [ADDR_WIDTH-3:0] cfg_addr,
  output logic [DATA_WIDTH-1:0] cfg_wr_data,
  input  logic [DATA_WIDTH-1:0] cfg_rd_data,
  input  logic                  cfg_rd_data_valid
);

  localparam int unsigned CFG_AW = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W  = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

  axil_state_e           state_q;
  axil_grant_e           last_grant_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic                  rd_err_q;
  logic                  cfg_wr_en_q;
  logic                  cfg_rd_en_q;
  logic [CFG_AW-1:0]     cfg_addr_q;
  logic [DATA_WIDTH-1:0] cfg_wr_data_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  wr_pop;
  logic                  wr_pending;
  logic                  rd_take;
  logic                  rd_timeout;

  assign wr_pop = (state_q == ST_WR_REQ);

  axil_skid_reg #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk     (clk),
    .reset   (reset),
    .valid_i (awvalid),
    .data_i  (awaddr),
    .ready_o (awready),
    .pop_i   (wr_pop),
    .full_o  (aw_full),
    .data_o  (aw_addr)
  );

  axil_skid_reg #(.WIDTH(DATA_WIDTH)) u_w_buf (
    .clk     (clk),
    .reset   (reset),
    .valid_i (wvalid),
    .data_i  (wdata),
    .ready_o (wready),
    .pop_i   (wr_pop),
    .full_o  (w_full),
    .data_o  (w_data)
  );

  // A ready write wins over a new read only when the last grant went to read.
  assign wr_pending = aw_full & w_full;
  assign arready    = (state_q == ST_IDLE) && !(wr_pending && (last_grant_q == GRANT_RD));
  assign rd_take    = arvalid & arready;
  assign rd_timeout = (rd_cnt_q == CNT_W'(RD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GRANT_WR;
      rd_cnt_q      <= '0;
      rd_err_q      <= 1'b0;
      cfg_wr_en_q   <= 1'b0;
      cfg_rd_en_q   <= 1'b0;
      cfg_addr_q    <= '0;
      cfg_wr_data_q <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= AXIL_OKAY;
      rvalid_q      <= 1'b0;
      rresp_q       <= AXIL_OKAY;
      rdata_q       <= '0;
    end else begin
      cfg_wr_en_q <= 1'b0;
      cfg_rd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rd_take) begin
            state_q      <= ST_RD_REQ;
            last_grant_q <= GRANT_RD;
            cfg_addr_q   <= araddr[ADDR_WIDTH-1:2];
            rd_err_q     <= !addr_aligned(araddr[1:0]);
            cfg_rd_en_q  <= addr_aligned(araddr[1:0]);
          end else if (wr_pending) begin
            state_q       <= ST_WR_REQ;
            last_grant_q  <= GRANT_WR;
            cfg_addr_q    <= aw_addr[ADDR_WIDTH-1:2];
            cfg_wr_data_q <= w_data;
            cfg_wr_en_q   <= addr_aligned(aw_addr[1:0]);
            bresp_q       <= addr_aligned(aw_addr[1:0]) ? AXIL_OKAY : AXIL_SLVERR;
          end
        end
        ST_WR_REQ: begin
          state_q  <= ST_WR_RESP;
          bvalid_q <= 1'b1;
        end
        ST_WR_RESP: begin
          if (bready) begin
            state_q  <= ST_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        ST_RD_REQ: begin
          state_q  <= ST_RD_WAIT;
          rd_cnt_q <= '0;
        end
        // Returned data takes priority over a timeout landing in the same cycle.
        ST_RD_WAIT: begin
          if (rd_err_q) begin
            state_q  <= ST_RD_RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= '0;
            rresp_q  <= AXIL_SLVERR;
          end else if (cfg_rd_data_valid) begin
            state_q  <= ST_RD_RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= cfg_rd_data;
            rresp_q  <= AXIL_OKAY;
          end else if (rd_timeout) begin
            state_q  <= ST_RD_RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= '0;
            rresp_q  <= AXIL_SLVERR;
          end else begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          end
        end
        ST_RD_RESP: begin
          if (rready) begin
            state_q  <= ST_IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_wr_en   = cfg_wr_en_q;
  assign cfg_rd_en   = cfg_rd_en_q;
  assign cfg_addr    = cfg_addr_q;
  assign cfg_wr_data = cfg_wr_data_q;
  assign bvalid      = bvalid_q;
  assign bresp       = bresp_q;
  assign rvalid      = rvalid_q;
  assign rresp       = rresp_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_axil_cfg_slave.sv
// Directed testbench for axil_cfg_slave: writes, reads, timeout, misaligned
// accesses, response back-pressure, mid-transaction reset and arbitration.
module tb_axil_cfg_slave;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic          cfg_wr_en;
  logic          cfg_rd_en;
  logic [AW-3:0] cfg_addr;
  logic [DW-1:0] cfg_wr_data;
  logic [DW-1:0] cfg_rd_data;
  logic          cfg_rd_data_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axil_cfg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_rd_data(cfg_rd_data),
    .cfg_rd_data_valid(cfg_rd_data_valid)
  );

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    cfg_rd_data = '0; cfg_rd_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    n_checks++; if (awready !== 1'b1) begin n_fail++; $display("FAIL reset_awready: got %0b want 1", awready); end
    n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL reset_wready: got %0b want 1", wready); end
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL reset_arready: got %0b want 1", arready); end
    n_checks++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got b=%0b r=%0b want 0 0", bvalid, rvalid); end
    n_checks++; if (cfg_wr_en !== 1'b0 || cfg_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got wr=%0b rd=%0b want 0 0", cfg_wr_en, cfg_rd_en); end
    n_checks++; if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got rdata=%0h rresp=%0b bresp=%0b want 0", rdata, rresp, bresp); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    bready = 1'b0;
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0; awaddr = 32'hFFFF_FFF0;
    n_checks++; if (awready !== 1'b0 || wready !== 1'b1) begin n_fail++; $display("FAIL wr_aw_buffered: got awready=%0b wready=%0b want 0 1", awready, wready); end
    tick(); tick();
    wdata = 32'hDEAD_BEEF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0; wdata = '0;
    n_checks++; if (cfg_wr_en !== 1'b0 || wready !== 1'b0) begin n_fail++; $display("FAIL wr_buffers_full: got wr_en=%0b wready=%0b want 0 0", cfg_wr_en, wready); end
    tick();
    n_checks++; if (cfg_wr_en !== 1'b1) begin n_fail++; $display("FAIL wr_strobe: got %0b want 1", cfg_wr_en); end
    n_checks++; if (cfg_addr !== 30'h4) begin n_fail++; $display("FAIL wr_addr: got %0h want 4", cfg_addr); end
    n_checks++; if (cfg_wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_data: got %0h want deadbeef", cfg_wr_data); end
    tick();
    n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got bvalid=%0b bresp=%0b want 1 00", bvalid, bresp); end
    n_checks++; if (cfg_wr_en !== 1'b0 || awready !== 1'b1) begin n_fail++; $display("FAIL wr_single_pulse: got wr_en=%0b awready=%0b want 0 1", cfg_wr_en, awready); end
    bready = 1'b1;
    tick();
    n_checks++; if (bvalid !== 1'b0 || cfg_wr_en !== 1'b0) begin n_fail++; $display("FAIL wr_done: got bvalid=%0b wr_en=%0b want 0 0", bvalid, cfg_wr_en); end
  endtask

  task automatic test_read();
    rready = 1'b0;
    araddr = 32'h20; arvalid = 1'b1;
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL rd_arready: got %0b want 1", arready); end
    tick();
    arvalid = 1'b0; araddr = '0;
    n_checks++; if (cfg_rd_en !== 1'b1 || cfg_addr !== 30'h8) begin n_fail++; $display("FAIL rd_strobe: got rd_en=%0b addr=%0h want 1 8", cfg_rd_en, cfg_addr); end
    // Stray data while still in the request cycle must not be captured.
    cfg_rd_data = 32'hBAD0_BAD0; cfg_rd_data_valid = 1'b1;
    tick();
    cfg_rd_data_valid = 1'b0;
    n_checks++; if (cfg_rd_en !== 1'b0 || rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_stray_ignored: got rd_en=%0b rvalid=%0b want 0 0", cfg_rd_en, rvalid); end
    repeat (4) tick();
    cfg_rd_data = 32'h1234; cfg_rd_data_valid = 1'b1;
    tick();
    cfg_rd_data_valid = 1'b0; cfg_rd_data = 32'hFFFF_FFFF;
    n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h1234 || rresp !== 2'b00) begin n_fail++; $display("FAIL rd_resp: got rvalid=%0b rdata=%0h rresp=%0b want 1 1234 00", rvalid, rdata, rresp); end
    tick();
    n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h1234) begin n_fail++; $display("FAIL rd_hold: got rvalid=%0b rdata=%0h want 1 1234", rvalid, rdata); end
    rready = 1'b1;
    tick();
    n_checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_fail++; $display("FAIL rd_done: got rvalid=%0b arready=%0b want 0 1", rvalid, arready); end
  endtask

  task automatic test_timeout();
    int first = 0;
    rready = 1'b0;
    araddr = 32'h8; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int k = 2; k <= int'(TO) + 10 && first == 0; k++) begin
      tick();
      if (rvalid === 1'b1) first = k;
    end
    n_checks++; if (first != int'(TO) + 2) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", first, TO + 2); end
    n_checks++; if (rresp !== 2'b10 || rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_resp: got rresp=%0b rdata=%0h want 10 0", rresp, rdata); end
    rready = 1'b1;
    tick();
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL timeout_done: got rvalid=%0b want 0", rvalid); end
  endtask

  task automatic test_timeout_race();
    rready = 1'b0;
    araddr = 32'hC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    repeat (TO) tick();
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL race_early: got rvalid=%0b want 0", rvalid); end
    cfg_rd_data = 32'h55AA; cfg_rd_data_valid = 1'b1;
    tick();
    cfg_rd_data_valid = 1'b0;
    n_checks++; if (rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== 32'h55AA) begin n_fail++; $display("FAIL race_valid_wins: got rvalid=%0b rresp=%0b rdata=%0h want 1 00 55aa", rvalid, rresp, rdata); end
    rready = 1'b1;
    tick();
  endtask

  task automatic test_misaligned_read();
    rready = 1'b0;
    araddr = 32'h6; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n_checks++; if (cfg_rd_en !== 1'b0) begin n_fail++; $display("FAIL misrd_no_strobe: got %0b want 0", cfg_rd_en); end
    tick(); tick();
    n_checks++; if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0) begin n_fail++; $display("FAIL misrd_resp: got rvalid=%0b rresp=%0b rdata=%0h want 1 10 0", rvalid, rresp, rdata); end
    rready = 1'b1;
    tick();
  endtask

  task automatic test_bresp_hold();
    int bad = 0;
    bready = 1'b0;
    awaddr = 32'h13; awvalid = 1'b1; wdata = 32'hCAFE; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    n_checks++; if (cfg_wr_en !== 1'b0) begin n_fail++; $display("FAIL miswr_no_strobe: got %0b want 0", cfg_wr_en); end
    tick();
    n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b10) begin n_fail++; $display("FAIL miswr_bresp: got bvalid=%0b bresp=%0b want 1 10", bvalid, bresp); end
    repeat (10) begin
      tick();
      if (bvalid !== 1'b1 || bresp !== 2'b10 || cfg_wr_en !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bresp_stable: got %0d unstable cycles want 0", bad); end
    bready = 1'b1;
    tick();
    n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL bresp_release: got bvalid=%0b want 0", bvalid); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    rready = 1'b0;
    araddr = 32'h40; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got arready=%0b rvalid=%0b want 1 0", arready, rvalid); end
    // Late data arriving in IDLE must be ignored as well.
    for (int k = 0; k < int'(TO) + 20; k++) begin
      cfg_rd_data_valid = (k == 5);
      cfg_rd_data = 32'h999;
      tick();
      if (rvalid === 1'b1 || cfg_rd_en === 1'b1) seen++;
    end
    cfg_rd_data_valid = 1'b0;
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_resp: got %0d cycles with rvalid/rd_en want 0", seen); end
    rready = 1'b1;
  endtask

  task automatic test_back_to_back();
    rready = 1'b0;
    awaddr = 32'h100; awvalid = 1'b1; wdata = 32'hA5A5_0001; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h200; arvalid = 1'b1;
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL rr_first_arready: got %0b want 1", arready); end
    tick();
    n_checks++; if (cfg_rd_en !== 1'b1 || cfg_wr_en !== 1'b0 || cfg_addr !== 30'h80) begin n_fail++; $display("FAIL rr_read_first: got rd_en=%0b wr_en=%0b addr=%0h want 1 0 80", cfg_rd_en, cfg_wr_en, cfg_addr); end
    araddr = 32'h300;
    tick();
    cfg_rd_data = 32'h77; cfg_rd_data_valid = 1'b1;
    tick();
    cfg_rd_data_valid = 1'b0;
    n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h77) begin n_fail++; $display("FAIL rr_read_data: got rvalid=%0b rdata=%0h want 1 77", rvalid, rdata); end
    rready = 1'b1;
    tick();
    n_checks++; if (arready !== 1'b0) begin n_fail++; $display("FAIL rr_write_turn_arready: got %0b want 0", arready); end
    tick();
    n_checks++; if (cfg_wr_en !== 1'b1 || cfg_rd_en !== 1'b0 || cfg_addr !== 30'h40 || cfg_wr_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rr_write_second: got wr_en=%0b rd_en=%0b addr=%0h data=%0h want 1 0 40 a5a50001", cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wr_data); end
    tick();
    n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_fail++; $display("FAIL rr_write_bresp: got bvalid=%0b bresp=%0b want 1 00", bvalid, bresp); end
    tick();
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL rr_read_turn_arready: got %0b want 1", arready); end
    tick();
    arvalid = 1'b0;
    n_checks++; if (cfg_rd_en !== 1'b1 || cfg_addr !== 30'hC0) begin n_fail++; $display("FAIL rr_read_third: got rd_en=%0b addr=%0h want 1 c0", cfg_rd_en, cfg_addr); end
    tick();
    cfg_rd_data = 32'h88; cfg_rd_data_valid = 1'b1;
    tick();
    cfg_rd_data_valid = 1'b0;
    n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h88 || rresp !== 2'b00) begin n_fail++; $display("FAIL rr_read_third_data: got rvalid=%0b rdata=%0h rresp=%0b want 1 88 00", rvalid, rdata, rresp); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_timeout_race();
    test_misaligned_read();
    test_bresp_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_cfg_slave.md
AXIL_CFG_SLAVE -- requirements
Module: axil_cfg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default CGRA_AXI_ADDR_WIDTH, AXI4-Lite byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default CGRA_AXI_DATA_WIDTH (32), data width.
REQ-003 SHALL have parameter RD_TIMEOUT, default 255, max cycles to wait for read data.
REQ-004 SHALL have one clock and a synchronous, active-high reset; the ports are clk and reset, and the polarity and synchronicity are fixed.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write-address channel.
- wdata/wvalid/wready  in/in/out  DATA_WIDTH/1/1  write-data channel.
- bresp/bvalid/bready  out/out/in  2/1/1  write-response channel.
- araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read-address channel.
- rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read-data channel.
- cfg_wr_en  out  1  one-cycle config write strobe.
- cfg_rd_en  out  1  one-cycle config read strobe.
- cfg_addr  out  ADDR_WIDTH-2  word address.
- cfg_wr_data  out  DATA_WIDTH  write data.
- cfg_rd_data  in  DATA_WIDTH  read data.
- cfg_rd_data_valid  in  1  qualifies cfg_rd_data.

Function
REQ-005 SHALL hold AW and W in independent one-entry buffers; awready = AW buffer empty, wready = W buffer empty; either channel may arrive first.
REQ-006 SHALL accept AR only in state IDLE with no granted write; arready = 1 only in IDLE.
REQ-007 SHALL use FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP; one config operation outstanding at a time.
REQ-008 IDLE->WR_REQ when both the AW and W buffers are full; IDLE->RD_REQ on an AR handshake.
REQ-009 When a write is ready and arvalid is high in the same IDLE cycle, SHALL grant round-robin: the opposite of the last grant; after reset, read is granted first.
REQ-010 WR_REQ SHALL pulse cfg_wr_en for exactly 1 cycle with cfg_addr = awaddr[ADDR_WIDTH-1:2], free both buffers, then go to WR_RESP.
REQ-011 WR_RESP SHALL hold bvalid=1 with bresp stable until bready; then return to IDLE.
REQ-012 RD_REQ SHALL pulse cfg_rd_en for 1 cycle, then go to RD_WAIT, clearing the timeout counter.
REQ-013 RD_WAIT SHALL capture cfg_rd_data on cfg_rd_data_valid with rresp=OKAY (2'b00); after RD_TIMEOUT cycles without valid, rdata=0 and rresp=SLVERR (2'b10); both cases go to RD_RESP.
REQ-014 cfg_rd_data_valid in the same cycle as the timeout SHALL win (OKAY).
REQ-015 cfg_rd_data_valid outside RD_WAIT SHALL be ignored.
REQ-016 RD_RESP SHALL hold rvalid=1 with rdata/rresp stable until rready; then return to IDLE.
REQ-017 Misaligned address (addr[1:0]!=0) SHALL skip the cfg strobe and respond SLVERR with the normal response latency.
REQ-018 Minimum latency SHALL be: write buffers full -> bvalid in 2 cycles; AR handshake -> cfg_rd_en the next cycle.

Reset
REQ-019 Reset SHALL force state IDLE, empty buffers, the last-grant bit to write (so read is granted first), counter 0, and all outputs 0 except awready=wready=arready=1 after the first reset cycle.
REQ-020 Reset mid-transaction SHALL abandon the operation silently; no response is issued after reset.

Structure
REQ-021 The state enum and the response codes OKAY/SLVERR SHALL live in global_buffer_param or a shared axil package.
REQ-022 The AW/W one-entry buffer SHALL be a sub-module, axil_skid_reg, instantiated twice.

Verification
REQ-023 AW 0x10 then W 0xDEADBEEF 3 cycles later -> single cfg_wr_en with addr 0x4 and data 0xDEADBEEF, then bvalid with bresp 00.
REQ-024 AR 0x20, cfg_rd_data_valid 5 cycles after cfg_rd_en with 0x1234 -> rdata 0x1234, rresp 00.
REQ-025 AR 0x8 with no valid -> rvalid at RD_TIMEOUT+2 cycles after AR, rresp 10, rdata 0.
REQ-026 Write ready and arvalid in the same cycle, twice in a row -> read served first, then write.
REQ-027 awaddr 0x13 -> no cfg_wr_en, bresp 10.
REQ-028 bready held low 10 cycles -> bvalid and bresp stable; then reset asserted during RD_WAIT -> IDLE, no rvalid.
